// File: rtl/mul_pkg.sv
// Shared types and widths for the sequential multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  localparam int unsigned MUL_W     = 16;
  localparam int unsigned MUL_PW    = 32;
  localparam int unsigned MUL_CNT_W = 4;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple adder with carry in/out, used as the partial-product accumulator.
module adder_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = 17'(a_i) + 17'(b_i) + 17'(cin_i);

endmodule

// File: rtl/mul_16bit_seq.sv
// Unsigned 16x16 -> 32 shift-add multiplier, one multiplier bit per cycle,
// valid/ready on both sides, one operation in flight.
module mul_16bit_seq
  import mul_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MUL_W-1:0]     A,
  input  logic [MUL_W-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MUL_PW-1:0]    P
);

  localparam logic [MUL_CNT_W-1:0] CntLast = MUL_CNT_W'(MUL_W - 1);

  mul_state_e             state_q;
  logic [MUL_W-1:0]       mcand_q;
  logic [MUL_W-1:0]       hi_q;
  logic [MUL_W-1:0]       lo_q;
  logic [MUL_CNT_W-1:0]   cnt_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [MUL_PW-1:0]      p_q;

  logic [MUL_W-1:0]       addend;
  logic [MUL_W-1:0]       sum;
  logic                   cout;
  logic [MUL_W-1:0]       hi_d;
  logic [MUL_W-1:0]       lo_d;
  logic [MUL_PW-1:0]      prod_step;
  logic [MUL_PW-1:0]      prod_out;
  logic                   rem_zero;
  logic                   last_step;

  assign addend = lo_q[0] ? mcand_q : '0;

  adder_16bit u_adder (
    .a_i    (hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // One accumulate-and-shift step: keep bits [32:1] of {carry, sum, lo}.
  always_comb begin
    {hi_d, lo_d} = {cout, sum, lo_q[MUL_W-1:1]};
    prod_step    = {hi_d, lo_d};
    // Multiplier bits still waiting above the one consumed this step.
    rem_zero     = ((lo_q >> 1) & (16'h7FFF >> cnt_q)) == '0;
    last_step    = (cnt_q == CntLast) || (EARLY_OUT && rem_zero);
    // On early exit the skipped steps would only shift right; do them at once.
    prod_out     = prod_step >> (CntLast - cnt_q);
  end

  // FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MUL_IDLE;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= A;
            hi_q       <= '0;
            lo_q       <= B;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (last_step) begin
            p_q         <= prod_out;
            out_valid_q <= 1'b1;
            state_q     <= MUL_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        MUL_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= MUL_IDLE;
          end
        end
        default: begin
          state_q <= MUL_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = p_q;

endmodule

// File: tb/tb_mul_16bit_seq.sv
// Directed and randomised checks for mul_16bit_seq, fixed-latency and early-out builds.
module tb_mul_16bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] a         [2];
  logic [15:0] b         [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] p         [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_16bit_seq #(.EARLY_OUT(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .A         (a[0]),
    .B         (b[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .P         (p[0])
  );

  mul_16bit_seq #(.EARLY_OUT(1'b1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .A         (a[1]),
    .B         (b[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .P         (p[1])
  );

  // Expected sample count from accept to first out_valid (one BUSY step per needed bit).
  function automatic int exp_lat(input int d, input logic [15:0] bv);
    int steps;
    steps = 1;
    if (d == 0) begin
      steps = 16;
    end else begin
      for (int i = 0; i < 16; i++) if (bv[i]) steps = i + 1;
    end
    return steps + 1;
  endfunction

  // Issue one op and collect it; starts and ends on a falling edge with the DUT idle.
  task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                        input int stall, output logic [31:0] pv, output int lat);
    int n;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout dut%0d in_ready=%0b required 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    a[d] = av;
    b[d] = bv;
    @(negedge clk);
    in_valid[d] = 1'b0;
    a[d] = 16'($urandom);
    b[d] = 16'($urandom);
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout dut%0d out_valid=%0b required 1", d, out_valid[d]);
    end
    repeat (stall) @(negedge clk);
    pv = p[d];
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready dut%0d got %0b required 1", d, in_ready[d]);
      end
      checks++;
      if (out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid dut%0d got %0b required 0", d, out_valid[d]);
      end
      checks++;
      if (p[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_p dut%0d got %h required 00000000", d, p[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] pv;
    int lat;
    run_op(0, 16'd3, 16'd5, 0, pv, lat);
    checks++;
    if (pv !== 32'h0000000F) begin
      errors++;
      $display("FAIL basic_p got %h required 0000000f", pv);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency got %0d required 17", lat);
    end
  endtask

  task automatic test_carry();
    logic [31:0] pv;
    int lat;
    for (int d = 0; d < 2; d++) begin
      run_op(d, 16'hFFFF, 16'hFFFF, 1, pv, lat);
      checks++;
      if (pv !== 32'hFFFE0001) begin
        errors++;
        $display("FAIL carry_ffff dut%0d got %h required fffe0001", d, pv);
      end
      run_op(d, 16'h8000, 16'h0002, 0, pv, lat);
      checks++;
      if (pv !== 32'h00010000) begin
        errors++;
        $display("FAIL carry_8000x2 dut%0d got %h required 00010000", d, pv);
      end
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL early_latency_b2 got %0d required 3", lat);
    end
  endtask

  task automatic test_zero();
    logic [31:0] pv;
    int lat;
    run_op(0, 16'h0000, 16'h1234, 0, pv, lat);
    checks++;
    if (pv !== 32'h0) begin
      errors++;
      $display("FAIL zero_a got %h required 00000000", pv);
    end
    run_op(0, 16'h1234, 16'h0000, 0, pv, lat);
    checks++;
    if (pv !== 32'h0) begin
      errors++;
      $display("FAIL zero_b got %h required 00000000", pv);
    end
    run_op(1, 16'h1234, 16'h0000, 0, pv, lat);
    checks++;
    if (pv !== 32'h0) begin
      errors++;
      $display("FAIL early_zero_b got %h required 00000000", pv);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL early_zero_latency got %0d required 2", lat);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    in_valid[0] = 1'b1;
    a[0] = 16'h00FF;
    b[0] = 16'h0101;
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || p[0] !== 32'h0000FFFF) begin
        errors++;
        $display("FAIL hold_stable cycle %0d out_valid=%0b p=%h required 1 0000ffff",
                 i, out_valid[0], p[0]);
      end
      if (i == 4) begin
        checks++;
        if (in_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL hold_in_ready got %0b required 0", in_ready[0]);
        end
        in_valid[0] = 1'b1;
        a[0] = 16'd5;
        b[0] = 16'd5;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL release out_valid=%0b in_ready=%0b required 0 1", out_valid[0], in_ready[0]);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ghost_op out_valid high for %0d cycles required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pv;
    int lat;
    int bad;
    in_valid[0] = 1'b1;
    a[0] = 16'h1234;
    b[0] = 16'h5678;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || p[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy in_ready=%0b out_valid=%0b p=%h required 1 0 00000000",
               in_ready[0], out_valid[0], p[0]);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_valid high for %0d cycles required 0", bad);
    end
    run_op(0, 16'd7, 16'd9, 0, pv, lat);
    checks++;
    if (pv !== 32'd63) begin
      errors++;
      $display("FAIL after_reset_p got %h required 0000003f", pv);
    end
    // Reset while holding a finished product.
    in_valid[1] = 1'b1;
    a[1] = 16'h00FF;
    b[1] = 16'h0003;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid[1] !== 1'b1 || p[1] !== 32'h000002FD) begin
      errors++;
      $display("FAIL early_done out_valid=%0b p=%h required 1 000002fd", out_valid[1], p[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || p[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_done out_valid=%0b in_ready=%0b p=%h required 0 1 00000000",
               out_valid[1], in_ready[1], p[1]);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int na;
    na = 0;
    acc[0] = 0;
    acc[1] = 0;
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    a[0] = 16'd2;
    b[0] = 16'd3;
    for (int k = 0; k < 60 && na < 2; k++) begin
      if (in_ready[0] === 1'b1) begin
        acc[na] = k;
        na++;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    repeat (20) @(negedge clk);
    out_ready[0] = 1'b0;
    checks++;
    if (na != 2 || acc[1] - acc[0] != 18) begin
      errors++;
      $display("FAIL issue_interval accepts=%0d interval=%0d required 2 18", na, acc[1] - acc[0]);
    end
    checks++;
    if (p[0] !== 32'd6 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain p=%h out_valid=%0b required 00000006 0", p[0], out_valid[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] pv;
    logic [31:0] expv;
    logic [15:0] av;
    logic [15:0] bv;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 800; i++) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        if (i % 4 == 1) bv = bv >> $urandom_range(1, 15);
        if (i % 16 == 3) av = 16'hFFFF;
        expv = {16'h0, av} * {16'h0, bv};
        run_op(d, av, bv, $urandom_range(0, 3), pv, lat);
        checks++;
        if (pv !== expv) begin
          errors++;
          $display("FAIL rand_p dut%0d %h*%h got %h required %h", d, av, bv, pv, expv);
        end
        checks++;
        if (lat != exp_lat(d, bv)) begin
          errors++;
          $display("FAIL rand_latency dut%0d b=%h got %0d required %0d", d, bv, lat,
                   exp_lat(d, bv));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      a[d]         = 16'h0;
      b[d]         = 16'h0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
